// File: rtl/apb_arb_pkg.sv
`default_nettype none
// ============================================================================
// apb_arb_pkg : shared defaults, state encoding and helpers for apb_req_arbiter
// Revision    : 1.0
// ============================================================================
package apb_arb_pkg;

    localparam int ADDR_W_DEF   = 9;
    localparam int DATA_W_DEF   = 8;
    localparam int ADDR_MAX_DEF = 'h03F;
    localparam int TIMEOUT_DEF  = 64;

    typedef enum logic [2:0] {
        ARB_IDLE  = 3'd0,
        ARB_ISSUE = 3'd1,
        ARB_WAIT  = 3'd2,
        ARB_RESP  = 3'd3,
        ARB_DRAIN = 3'd4
    } arb_state_e;

    // The counter only has to hold 0..TIMEOUT-1; keep at least one bit.
    function automatic int cnt_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_rr_pick.sv
`default_nettype none
// ============================================================================
// apb_rr_pick : combinational two-way round-robin picker, one-hot grant
// Revision    : 1.0
// ============================================================================
module apb_rr_pick
    import apb_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

    // On contention the requester that was not granted last wins.
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/apb_req_arbiter.sv
`default_nettype none
// ============================================================================
// apb_req_arbiter : shares one APB master between two requesters, one command
//                   outstanding, with range check and completion timeout
// Revision        : 1.0
// ============================================================================
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(ADDR_MAX_DEF),
    parameter int                TIMEOUT  = TIMEOUT_DEF
)(
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic [1:0]        REQ_VALID,
    input  logic [1:0]        REQ_WRITE,
    input  logic [ADDR_W-1:0] REQ_ADDR0,
    input  logic [ADDR_W-1:0] REQ_ADDR1,
    input  logic [DATA_W-1:0] REQ_WDATA0,
    input  logic [DATA_W-1:0] REQ_WDATA1,
    output logic [1:0]        REQ_READY,
    output logic [1:0]        RSP_VALID,
    output logic [DATA_W-1:0] RSP_RDATA,
    output logic              RSP_ERR,
    output logic              ST,
    output logic              WEN,
    output logic [ADDR_W-1:0] APB_WADRS,
    output logic [ADDR_W-1:0] APB_RADRS,
    output logic [DATA_W-1:0] APB_WDATA,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PREADY,
    input  logic              PLSVERR,
    input  logic [DATA_W-1:0] PRDATA
);

    localparam int              CNT_W    = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [2:0] ST_IDLE  = ARB_IDLE;
    localparam logic [2:0] ST_ISSUE = ARB_ISSUE;
    localparam logic [2:0] ST_WAIT  = ARB_WAIT;
    localparam logic [2:0] ST_RESP  = ARB_RESP;
    localparam logic [2:0] ST_DRAIN = ARB_DRAIN;

    logic [2:0]        state;
    logic              rr_ptr;      // requester favoured on the next contention
    logic              gnt_idx;
    logic              timed_out;
    logic [CNT_W-1:0]  cnt;

    logic              st_q;
    logic              wen_q;
    logic [ADDR_W-1:0] wadrs_q;
    logic [ADDR_W-1:0] radrs_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic [1:0]        pick;
    logic              pick_last;
    logic              sel_idx;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_bad;
    logic              accept;
    logic              bus_setup;
    logic              bus_done;
    logic              expired;

    assign pick_last = ~rr_ptr;

    apb_rr_pick u_pick (
        .valid (REQ_VALID),
        .last  (pick_last),
        .grant (pick)
    );

    always_comb begin
        sel_idx   = pick[1];
        sel_write = sel_idx ? REQ_WRITE[1] : REQ_WRITE[0];
        sel_addr  = sel_idx ? REQ_ADDR1    : REQ_ADDR0;
        sel_wdata = sel_idx ? REQ_WDATA1   : REQ_WDATA0;
        sel_bad   = (sel_addr > ADDR_MAX);
        accept    = (state == ST_IDLE) && (pick != 2'b00);
        bus_setup = PSEL & ~PENABLE;
        bus_done  = PSEL & PENABLE & PREADY;
        expired   = (cnt == CNT_LAST);
    end

    // Accept is combinational so the handshake lands in the IDLE cycle itself;
    // masking with reset keeps a dropped handshake from being seen.
    assign REQ_READY = (PRESETn && (state == ST_IDLE)) ? pick : 2'b00;
    assign RSP_VALID = (state == ST_RESP) ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
    assign RSP_RDATA = (state == ST_RESP) ? rdata_q : '0;
    assign RSP_ERR   = (state == ST_RESP) && err_q;

    assign ST        = st_q;
    assign WEN       = wen_q;
    assign APB_WADRS = wadrs_q;
    assign APB_RADRS = radrs_q;
    assign APB_WDATA = wdata_q;

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state     <= ST_IDLE;
            rr_ptr    <= 1'b0;
            gnt_idx   <= 1'b0;
            timed_out <= 1'b0;
            cnt       <= '0;
            st_q      <= 1'b0;
            wen_q     <= 1'b0;
            wadrs_q   <= '0;
            radrs_q   <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        gnt_idx <= sel_idx;
                        rdata_q <= '0;
                        if (sel_bad) begin
                            // Out-of-range: answer locally, never touch the bus.
                            err_q <= 1'b1;
                            state <= ST_RESP;
                        end else begin
                            err_q   <= 1'b0;
                            st_q    <= 1'b1;
                            wen_q   <= sel_write;
                            wadrs_q <= sel_write ? sel_addr  : '0;
                            radrs_q <= sel_write ? '0        : sel_addr;
                            wdata_q <= sel_write ? sel_wdata : '0;
                            cnt     <= '0;
                            state   <= ST_ISSUE;
                        end
                    end
                end

                ST_ISSUE: begin
                    cnt <= cnt + CNT_W'(1);
                    if (expired) begin
                        st_q      <= 1'b0;
                        err_q     <= 1'b1;
                        rdata_q   <= '0;
                        timed_out <= 1'b1;
                        state     <= ST_RESP;
                    end else if (bus_setup) begin
                        // Dropping ST here lets the master return to IDLE after this transfer.
                        st_q  <= 1'b0;
                        state <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (bus_done) begin
                        rdata_q <= (!wen_q && !PLSVERR) ? PRDATA : '0;
                        err_q   <= PLSVERR;
                        state   <= ST_RESP;
                    end else if (expired) begin
                        st_q      <= 1'b0;
                        err_q     <= 1'b1;
                        rdata_q   <= '0;
                        timed_out <= 1'b1;
                        state     <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    rr_ptr    <= ~gnt_idx;
                    wen_q     <= 1'b0;
                    wadrs_q   <= '0;
                    radrs_q   <= '0;
                    wdata_q   <= '0;
                    cnt       <= '0;
                    timed_out <= 1'b0;
                    // An aborted transfer may still own the bus; wait for it to let go.
                    state     <= timed_out ? ST_DRAIN : ST_IDLE;
                end

                ST_DRAIN: begin
                    if (!PSEL) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    st_q  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_req_arbiter.sv
`default_nettype none
// ============================================================================
// tb_apb_req_arbiter : directed bench for apb_req_arbiter with a hand-driven
//                      APB master/bus model
// Revision           : 1.0
// ============================================================================
module tb_apb_req_arbiter;

    logic       PCLK       = 1'b0;
    logic       PRESETn    = 1'b0;
    logic [1:0] REQ_VALID  = 2'b00;
    logic [1:0] REQ_WRITE  = 2'b00;
    logic [8:0] REQ_ADDR0  = '0;
    logic [8:0] REQ_ADDR1  = '0;
    logic [7:0] REQ_WDATA0 = '0;
    logic [7:0] REQ_WDATA1 = '0;
    logic       PSEL       = 1'b0;
    logic       PENABLE    = 1'b0;
    logic       PREADY     = 1'b0;
    logic       PLSVERR    = 1'b0;
    logic [7:0] PRDATA     = '0;

    logic [1:0] REQ_READY;
    logic [1:0] RSP_VALID;
    logic [7:0] RSP_RDATA;
    logic       RSP_ERR;
    logic       ST;
    logic       WEN;
    logic [8:0] APB_WADRS;
    logic [8:0] APB_RADRS;
    logic [7:0] APB_WDATA;

    int checks   = 0;
    int failures = 0;

    apb_req_arbiter #(
        .ADDR_W   (9),
        .DATA_W   (8),
        .ADDR_MAX (9'h03F),
        .TIMEOUT  (8)
    ) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .REQ_VALID  (REQ_VALID),
        .REQ_WRITE  (REQ_WRITE),
        .REQ_ADDR0  (REQ_ADDR0),
        .REQ_ADDR1  (REQ_ADDR1),
        .REQ_WDATA0 (REQ_WDATA0),
        .REQ_WDATA1 (REQ_WDATA1),
        .REQ_READY  (REQ_READY),
        .RSP_VALID  (RSP_VALID),
        .RSP_RDATA  (RSP_RDATA),
        .RSP_ERR    (RSP_ERR),
        .ST         (ST),
        .WEN        (WEN),
        .APB_WADRS  (APB_WADRS),
        .APB_RADRS  (APB_RADRS),
        .APB_WDATA  (APB_WDATA),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PREADY     (PREADY),
        .PLSVERR    (PLSVERR),
        .PRDATA     (PRDATA)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the edge; outputs are sampled 1 unit later.
    task automatic cyc();
        @(posedge PCLK);
        #2;
    endtask

    task automatic bus(input logic sel, input logic en, input logic rdy);
        PSEL    = sel;
        PENABLE = en;
        PREADY  = rdy;
    endtask

    initial begin
        // ---------------- reset ----------------
        cyc();
        cyc();
        PRESETn = 1'b1;
        #1;
        chk("rst_st",    ST,        0);
        chk("rst_ready", REQ_READY, 0);
        chk("rst_rsp",   RSP_VALID, 0);
        chk("rst_wen",   WEN,       0);
        chk("rst_wadrs", APB_WADRS, 0);
        chk("rst_radrs", APB_RADRS, 0);
        chk("rst_wdata", APB_WDATA, 0);

        // ---------------- single write, zero wait ----------------
        cyc();
        REQ_VALID = 2'b01; REQ_WRITE = 2'b01; REQ_ADDR0 = 9'h010; REQ_WDATA0 = 8'hA5;
        #1;
        chk("w_ready", REQ_READY, 2'b01);
        chk("w_st_c0", ST,        0);
        cyc();
        REQ_VALID = 2'b00;
        #1;
        chk("w_st_c1",  ST,        1);
        chk("w_wen",    WEN,       1);
        chk("w_wadrs",  APB_WADRS, 9'h010);
        chk("w_radrs",  APB_RADRS, 0);
        chk("w_wdata",  APB_WDATA, 8'hA5);
        chk("w_rdy_c1", REQ_READY, 0);
        cyc();
        bus(1, 0, 0);
        #1;
        chk("w_st_c2", ST, 1);
        cyc();
        bus(1, 1, 1);
        #1;
        chk("w_st_c3",  ST,        0);
        chk("w_rsp_c3", RSP_VALID, 0);
        cyc();
        bus(0, 0, 0);
        #1;
        chk("w_rsp_c4",   RSP_VALID, 2'b01);
        chk("w_err",      RSP_ERR,   0);
        chk("w_rdata",    RSP_RDATA, 0);
        chk("w_wadrs_c4", APB_WADRS, 9'h010);
        cyc();
        #1;
        chk("w_rsp_c5",   RSP_VALID, 0);
        chk("w_wen_c5",   WEN,       0);
        chk("w_wadrs_c5", APB_WADRS, 0);

        // ---------------- read, 3 wait states (IDLE cycle reused) ----------------
        REQ_VALID = 2'b10; REQ_WRITE = 2'b00; REQ_ADDR1 = 9'h020; PRDATA = 8'hFF;
        #1;
        chk("r_ready", REQ_READY, 2'b10);
        cyc();
        REQ_VALID = 2'b00;
        #1;
        chk("r_st",    ST,        1);
        chk("r_wen",   WEN,       0);
        chk("r_radrs", APB_RADRS, 9'h020);
        chk("r_wadrs", APB_WADRS, 0);
        chk("r_wdata", APB_WDATA, 0);
        cyc();
        bus(1, 0, 0);
        cyc();
        bus(1, 1, 0);
        PLSVERR = 1'b1;
        cyc();
        PLSVERR = 1'b0;
        cyc();
        #1;
        chk("r_rsp_c5", RSP_VALID, 0);
        cyc();
        PREADY = 1'b1; PRDATA = 8'h3C;
        #1;
        chk("r_rsp_c6", RSP_VALID, 0);
        cyc();
        bus(0, 0, 0);
        PRDATA = 8'hFF;
        #1;
        chk("r_rsp_c7", RSP_VALID, 2'b10);
        chk("r_rdata",  RSP_RDATA, 8'h3C);
        chk("r_err",    RSP_ERR,   0);
        cyc();

        // ---------------- contention: both valid for 4 transfers ----------------
        REQ_VALID = 2'b11; REQ_WRITE = 2'b01;
        REQ_ADDR0 = 9'h011; REQ_WDATA0 = 8'h11; REQ_ADDR1 = 9'h022; PRDATA = 8'h5A;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] exp_g;
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            chk("c_ready", REQ_READY, exp_g);
            cyc();
            #1;
            chk("c_st",      ST,        1);
            chk("c_rdy_bsy", REQ_READY, 0);
            if (k % 2 == 0) chk("c_wadrs", APB_WADRS, 9'h011);
            else            chk("c_radrs", APB_RADRS, 9'h022);
            cyc();
            bus(1, 0, 0);
            cyc();
            bus(1, 1, 1);
            cyc();
            bus(0, 0, 0);
            #1;
            chk("c_rsp",   RSP_VALID, exp_g);
            chk("c_rdata", RSP_RDATA, (k % 2 == 0) ? 32'h0 : 32'h5A);
            cyc();
        end
        REQ_VALID = 2'b00;

        // ---------------- out-of-range address ----------------
        REQ_VALID = 2'b01; REQ_WRITE = 2'b00; REQ_ADDR0 = 9'h040;
        #1;
        chk("o_ready", REQ_READY, 2'b01);
        cyc();
        REQ_VALID = 2'b00;
        #1;
        chk("o_rsp",   RSP_VALID, 2'b01);
        chk("o_err",   RSP_ERR,   1);
        chk("o_rdata", RSP_RDATA, 0);
        chk("o_st",    ST,        0);
        chk("o_radrs", APB_RADRS, 0);
        cyc();
        #1;
        chk("o_rsp_c2", RSP_VALID, 0);
        chk("o_st_c2",  ST,        0);

        // ---------------- timeout (addr at ADDR_MAX accepted) ----------------
        REQ_VALID = 2'b10; REQ_WRITE = 2'b00; REQ_ADDR1 = 9'h03F;
        #1;
        chk("t_ready", REQ_READY, 2'b10);
        cyc();
        REQ_VALID = 2'b00;
        #1;
        chk("t_st",    ST,        1);
        chk("t_radrs", APB_RADRS, 9'h03F);
        cyc();
        bus(1, 0, 0);
        cyc();
        bus(1, 1, 0);
        repeat (5) cyc();
        #1;
        chk("t_rsp_c8", RSP_VALID, 0);
        cyc();
        #1;
        chk("t_rsp_c9", RSP_VALID, 2'b10);
        chk("t_err",    RSP_ERR,   1);
        chk("t_rdata",  RSP_RDATA, 0);
        cyc();
        REQ_VALID = 2'b11;
        #1;
        chk("t_drain1", REQ_READY, 0);
        chk("t_st_dr",  ST,        0);
        cyc();
        #1;
        chk("t_drain2", REQ_READY, 0);
        cyc();
        bus(0, 0, 0);
        #1;
        chk("t_drain3", REQ_READY, 0);
        cyc();

        // ---------------- reset during WAIT ----------------
        REQ_WRITE = 2'b01; REQ_ADDR0 = 9'h005; REQ_WDATA0 = 8'h77;
        #1;
        chk("d_ready", REQ_READY, 2'b01);
        cyc();
        REQ_VALID = 2'b00;
        #1;
        chk("d_st",    ST,        1);
        chk("d_wadrs", APB_WADRS, 9'h005);
        chk("d_wdata", APB_WDATA, 8'h77);
        cyc();
        bus(1, 0, 0);
        cyc();
        bus(1, 1, 0);
        PRESETn = 1'b0;
        #1;
        chk("d_st_wait", ST, 0);
        cyc();
        PRESETn = 1'b1;
        bus(0, 0, 0);
        #1;
        chk("d_st_rst",    ST,        0);
        chk("d_wen_rst",   WEN,       0);
        chk("d_wadrs_rst", APB_WADRS, 0);
        chk("d_wdata_rst", APB_WDATA, 0);
        chk("d_rsp_rst",   RSP_VALID, 0);
        cyc();
        #1;
        chk("d_rsp_late", RSP_VALID, 0);

        // ---------------- post-reset contention + slave error on read ----------------
        REQ_VALID = 2'b11; REQ_WRITE = 2'b00; REQ_ADDR0 = 9'h001; REQ_ADDR1 = 9'h002;
        #1;
        chk("e_ready", REQ_READY, 2'b01);
        cyc();
        REQ_VALID = 2'b00;
        #1;
        chk("e_radrs", APB_RADRS, 9'h001);
        cyc();
        bus(1, 0, 0);
        cyc();
        bus(1, 1, 1);
        PLSVERR = 1'b1; PRDATA = 8'h99;
        cyc();
        bus(0, 0, 0);
        PLSVERR = 1'b0;
        #1;
        chk("e_rsp",   RSP_VALID, 2'b01);
        chk("e_err",   RSP_ERR,   1);
        chk("e_rdata", RSP_RDATA, 0);
        cyc();
        #1;
        chk("e_rsp_c5", RSP_VALID, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Two-port round-robin front end that shares the single APB master between two requesters (e.g. config engine and debug port). It accepts one command at a time and drives the master's command inputs (ST, WEN, APB_WADRS, APB_RADRS, APB_WDATA). It monitors the APB bus to detect completion and returns read data and error status to the requester that was granted.

## Interface
- ADDR_W, 9, address width (matches PADDR)
- DATA_W, 8, data width
- ADDR_MAX, 9'h03F, highest legal address; anything above is rejected locally
- TIMEOUT, 64, max cycles from ST assertion to completion before abort
- PCLK  in  1  clock; one clock domain, all logic on rising edge
- PRESETn  in  1  reset, synchronous, active-low
- REQ_VALID[1:0]  in  2  per-requester command valid; held until accepted
- REQ_WRITE[1:0]  in  2  1=write, 0=read
- REQ_ADDR0, REQ_ADDR1  in  ADDR_W  command address
- REQ_WDATA0, REQ_WDATA1  in  DATA_W  write data
- REQ_READY[1:0]  out  2  one-cycle accept pulse
- RSP_VALID[1:0]  out  2  one-cycle response pulse
- RSP_RDATA  out  DATA_W  read data, qualified by RSP_VALID; 0 for writes and errors
- RSP_ERR  out  1  error flag, qualified by RSP_VALID
- ST, WEN  out  1  to master
- APB_WADRS, APB_RADRS  out  ADDR_W  to master
- APB_WDATA  out  DATA_W  to master
- PSEL, PENABLE, PREADY, PLSVERR  in  1  bus/master monitor
- PRDATA  in  DATA_W  bus read data

## Operation
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE
  - If any REQ_VALID is set, grant one requester:
    - Both valid: grant the one not granted last.
    - Pointer after reset favours requester 0.
  - Pulse REQ_READY for the granted requester and latch WRITE/ADDR/WDATA.
  - If ADDR > ADDR_MAX, go to RESP with err=1 and issue no bus transfer. Otherwise go to ISSUE.
- ISSUE
  - ST=1. WEN=latched write.
  - Route the latched address to APB_WADRS (write) or APB_RADRS (read); drive the other address with 0.
  - Drive APB_WDATA with the latched data on writes, 0 on reads.
  - When PSEL=1 and PENABLE=0 (master in SETUP), clear ST and go to WAIT.
- WAIT
  - On PSEL & PENABLE & PREADY:
    - Capture PRDATA (reads only).
    - Capture err = PLSVERR.
    - Go to RESP.
  - ST stays 0, so the master returns to IDLE after completion.
- RESP
  - Pulse RSP_VALID for the granted requester for one cycle with RSP_RDATA/RSP_ERR.
  - Update the round-robin pointer; this also applies to rejected commands.
  - Go to IDLE.
- Timeout
  - The counter starts at 0 on entry to ISSUE and increments every cycle in ISSUE/WAIT.
  - On reaching TIMEOUT-1 without completion: clear ST, capture err=1 and rdata=0, go to RESP.
  - From that RESP, go to DRAIN instead of IDLE.
- DRAIN
  - No grants.
  - Leave for IDLE on the first cycle PSEL=0.
- Command outputs (WEN, addresses, WDATA) stay stable from ISSUE entry through RESP.
- They return to 0 in IDLE.

## Timing
- Reset: all outputs 0, state IDLE, pointer=0, counter=0.
- Reset asserted mid-transfer: the pending command is dropped with no RSP_VALID. ST falls at the next edge.
- Accept → ST high: 1 cycle (ST is registered).
- Zero-wait transfer:
  - Accept at cycle 0, ST in cycles 1-2, master SETUP in cycle 2, ACCESS with PREADY in cycle 3.
  - RSP_VALID in cycle 4.
  - Next accept no earlier than cycle 5.
- Each PREADY wait state adds 1 cycle.
- Rejected command: RSP_VALID one cycle after REQ_READY.
- At most one outstanding command. REQ_VALID of the non-granted requester is ignored until IDLE.
- PLSVERR is sampled only in the completion cycle.

## Structure
- Package apb_arb_pkg holds:
  - state encoding (3-bit enum),
  - ADDR_W/DATA_W defaults,
  - ADDR_MAX default,
  - the timeout counter width derived from TIMEOUT.
- One sub-module: apb_rr_pick, a combinational 2-way round-robin picker (inputs: valid[1:0], last; output: grant one-hot).
- FSM, latch registers and counter stay in the top module.

## Test plan
- Single write: req0 write addr 0x010 data 0xA5, PREADY=1 → ST high 2 cycles, APB_WADRS=0x010/WEN=1, RSP_VALID[0] 4 cycles after accept, RSP_ERR=0.
- Read with 3 wait states: req1 read 0x020, PRDATA=0x3C at completion → RSP_RDATA=0x3C, RSP_VALID[1] at cycle 7.
- Contention: both valid every cycle for 4 transfers → grants alternate 0,1,0,1; both valid after reset → req0 first.
- Out of range: req0 addr 0x040 → REQ_READY then RSP_VALID[0] with RSP_ERR=1 next cycle, ST never asserted.
- Timeout: PREADY held 0, TIMEOUT=8 → RSP_ERR=1 after 8 cycles, no grant until PSEL=0.
- Reset in WAIT: PRESETn low 1 cycle → all outputs 0 next edge, no RSP_VALID, next grant to req0.
